// File: rtl/writeback_pc_unit_if.sv
// Instruction-memory fetch handshake between writeback_pc_unit (master) and imem (slave).
interface writeback_pc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/writeback_pc_unit.sv
// PC, register file and fetch/commit sequencer for the single-cycle core.
// Optional macro WB_PC_RELATIVE_EN: branch target is pc-relative instead of absolute.
module writeback_pc_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    writeback_pc_unit_if.master        imem,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    input  logic [4:0]                 rd_addr,
    output logic [31:0]                rs1_data,
    output logic [31:0]                rs2_data,
    input  logic [31:0]                sonuc,
    input  logic                       pc_update,
    input  logic                       we,
    input  logic                       hata,
    output logic [31:0]                pc,
    output logic                       halted,
    output logic [1:0]                 err_code
);

    localparam int unsigned CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [31:0]   regs [32];
    logic          timeout;
    logic          taken;
    logic          reg_write;
    logic [31:0]   target;
    logic [31:0]   pc_next;

    assign timeout   = (cnt == CW'(FETCH_TIMEOUT - 1));
    assign reg_write = (state == EXEC) && !hata && we && (rd_addr != 5'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; ack beats a same-cycle timeout, hata beats commit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                if (imem.imem_ack) begin
                    state_next = EXEC;
                end else if (timeout) begin
                    state_next = HALT;
                end
            end
            EXEC:  state_next = hata ? HALT : FETCH;
            HALT:  state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        imem.imem_req  = (state == FETCH);
        imem.imem_addr = pc;
        instr_valid    = (state == EXEC);
        halted         = (state == HALT);
    end

    // X/Z on pc_update must not redirect the PC
    always_comb begin
        taken = (pc_update === 1'b1);
`ifdef WB_PC_RELATIVE_EN
        target = pc + (sonuc << 1);
`else
        target = sonuc << 1;
`endif
        pc_next = taken ? target : pc + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr    <= '0;
            cnt      <= '0;
            err_code <= 2'b00;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr <= imem.imem_rdata;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (timeout) begin
                            err_code <= 2'b10;
                        end
                    end
                end
                EXEC: begin
                    if (hata) begin
                        err_code <= 2'b01;
                    end else begin
                        pc <= pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write) begin
            regs[rd_addr] <= sonuc;
        end
    end

    // Reads see pre-commit contents; reg 0 is hardwired to zero
    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
    end

endmodule

// File: tb/tb_writeback_pc_unit.sv
// Scoreboard bench for writeback_pc_unit: expected fetch addresses queued at commit, popped at fetch.
module tb_writeback_pc_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int unsigned TO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr;
    logic        instr_valid;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [4:0]  rd_addr  = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] sonuc     = '0;
    logic        pc_update = 1'b0;
    logic        we        = 1'b0;
    logic        hata      = 1'b0;
    logic [31:0] pc;
    logic        halted;
    logic [1:0]  err_code;

    writeback_pc_unit_if imem();

    writeback_pc_unit #(
        .RESET_PC      (RPC),
        .FETCH_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .sonuc       (sonuc),
        .pc_update   (pc_update),
        .we          (we),
        .hata        (hata),
        .pc          (pc),
        .halted      (halted),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr_q [$];
    logic [31:0] mregs [32];
    logic [31:0] mpc;

    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
    end

    task automatic model_reset();
        mpc = RPC;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        exp_addr_q.delete();
        exp_addr_q.push_back(RPC);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        imem.imem_ack = 1'b0;
        we = 1'b0; pc_update = 1'b0; hata = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Waits for the request, checks its address against the scoreboard, acks after 'waits' cycles.
    task automatic do_fetch(input int waits, input logic [31:0] word, input bit immediate);
        int n = 0;
        logic [31:0] ea;
        while (imem.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (imem.imem_req !== 1'b1 || (immediate && n != 0)) begin
            bad++;
            $display("FAIL fetch_req: got req=%b after %0d cycles, want req=1 after %0d", imem.imem_req, n, immediate ? 0 : n);
        end
        ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
        total++;
        if (imem.imem_addr !== ea) begin
            bad++;
            $display("FAIL fetch_addr: got %h want %h", imem.imem_addr, ea);
        end
        repeat (waits) @(negedge clk);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = word;
        @(negedge clk);
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        total++;
        if (instr_valid !== 1'b1 || instr !== word) begin
            bad++;
            $display("FAIL exec_entry: got valid=%b instr=%h want valid=1 instr=%h", instr_valid, instr, word);
        end
    endtask

    task automatic do_exec(input logic w, input logic [4:0] rd, input logic [31:0] s,
                           input logic pcu, input logic h);
        logic [31:0] tgt;
        rs1_addr = rd; rd_addr = rd; we = w; sonuc = s; pc_update = pcu; hata = h;
        #1;
        total++;
        if (rs1_data !== mregs[rd]) begin
            bad++;
            $display("FAIL precommit_read r%0d: got %h want %h", rd, rs1_data, mregs[rd]);
        end
        total++;
        if (pc !== mpc) begin
            bad++;
            $display("FAIL exec_pc: got %h want %h", pc, mpc);
        end
        @(negedge clk);
        we = 1'b0; pc_update = 1'b0; hata = 1'b0;
        if (!h) begin
            if (w && rd != 5'd0) mregs[rd] = s;
`ifdef WB_PC_RELATIVE_EN
            tgt = mpc + {s[30:0], 1'b0};
`else
            tgt = {s[30:0], 1'b0};
`endif
            mpc = (pcu === 1'b1) ? tgt : mpc + 32'd4;
            exp_addr_q.push_back(mpc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
            err_code !== 2'b00 || pc !== RPC || instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got req=%b valid=%b halted=%b err=%b pc=%h instr=%h want 0 0 0 00 %h 0",
                     imem.imem_req, instr_valid, halted, err_code, pc, instr, RPC);
        end
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (imem.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_req: got %b want 0", imem.imem_req);
        end
        do_fetch(0, 32'h0000_0013, 0);
        do_exec(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        total++;
        if (pc !== RPC + 32'd4) begin
            bad++;
            $display("FAIL first_pc_step: got %h want %h", pc, RPC + 32'd4);
        end
    endtask

    task automatic test_regwrite();
        do_fetch(0, 32'h1111_0001, 1);
        do_exec(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        rs1_addr = 5'd5;
        #1;
        total++;
        if (rs1_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL reg5_write: got %h want deadbeef", rs1_data);
        end
        do_fetch(0, 32'h1111_0002, 1);
        do_exec(1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd5;
        #1;
        total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL reg0_ignore: got rs1=%h rs2=%h want 0 deadbeef", rs1_data, rs2_data);
        end
    endtask

    task automatic test_branch();
        logic [31:0] pre;
        do_fetch(0, 32'h2222_0001, 1);
        do_exec(1'b0, 5'd0, 32'h0000_0020, 1'b1, 1'b0);
        pre = pc;
        do_fetch(0, 32'h2222_0002, 1);
        do_exec(1'b0, 5'd0, 32'h0000_0010, 1'b1, 1'b0);
        total++;
`ifdef WB_PC_RELATIVE_EN
        if (pc !== pre + 32'h20) begin
            bad++;
            $display("FAIL branch_target: got %h want %h", pc, pre + 32'h20);
        end
`else
        if (pc !== 32'h20 || pre !== 32'h40) begin
            bad++;
            $display("FAIL branch_target: got from %h to %h want from 00000040 to 00000020", pre, pc);
        end
`endif
        pre = pc;
        do_fetch(0, 32'h2222_0003, 1);
        do_exec(1'b0, 5'd0, 32'h0000_0300, 1'bx, 1'b0);
        total++;
        if (pc !== pre + 32'd4) begin
            bad++;
            $display("FAIL branch_x_not_taken: got %h want %h", pc, pre + 32'd4);
        end
        do_fetch(0, 32'h2222_0004, 1);
        do_exec(1'b0, 5'd0, 32'h7FFF_FFFE, 1'b1, 1'b0);
        do_fetch(0, 32'h2222_0005, 1);
        do_exec(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        total++;
        if (pc !== mpc) begin
            bad++;
            $display("FAIL pc_wrap: got %h want %h", pc, mpc);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            do_fetch(0, $urandom, 1);
            do_exec(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 3) == 0), 1'b0);
        end
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r);
            rs2_addr = 5'(31 - r);
            #1;
            total++;
            if (rs1_data !== mregs[r] || rs2_data !== mregs[31 - r]) begin
                bad++;
                $display("FAIL regfile_r%0d: got %h/%h want %h/%h", r, rs1_data, rs2_data,
                         mregs[r], mregs[31 - r]);
            end
        end
    endtask

    task automatic test_exec_error();
        logic [31:0] pre;
        do_fetch(0, 32'h3333_0001, 1);
        pre = mpc;
        do_exec(1'b1, 5'd9, 32'h0000_CAFE, 1'b1, 1'b1);
        rs1_addr = 5'd9;
        #1;
        total++;
        if (halted !== 1'b1 || err_code !== 2'b01 || imem.imem_req !== 1'b0 ||
            pc !== pre || rs1_data !== mregs[9]) begin
            bad++;
            $display("FAIL exec_error: got halted=%b err=%b req=%b pc=%h r9=%h want 1 01 0 %h %h",
                     halted, err_code, imem.imem_req, pc, rs1_data, pre, mregs[9]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (halted !== 1'b1 || imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== pre) begin
            bad++;
            $display("FAIL halt_frozen: got halted=%b req=%b valid=%b pc=%h want 1 0 0 %h",
                     halted, imem.imem_req, instr_valid, pc, pre);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        apply_reset();
        while (imem.imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        void'(exp_addr_q.pop_front());
        repeat (TO - 1) @(negedge clk);
        total++;
        if (imem.imem_req !== 1'b1 || halted !== 1'b0) begin
            bad++;
            $display("FAIL timeout_last_wait: got req=%b halted=%b want 1 0", imem.imem_req, halted);
        end
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || err_code !== 2'b10 || imem.imem_req !== 1'b0 || pc !== RPC) begin
            bad++;
            $display("FAIL timeout_halt: got halted=%b err=%b req=%b pc=%h want 1 10 0 %h",
                     halted, err_code, imem.imem_req, pc, RPC);
        end
        apply_reset();
        do_fetch(TO - 1, 32'h4444_0001, 0);
        do_exec(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        total++;
        if (halted !== 1'b0 || err_code !== 2'b00 || pc !== RPC + 32'd4) begin
            bad++;
            $display("FAIL ack_at_limit: got halted=%b err=%b pc=%h want 0 00 %h",
                     halted, err_code, pc, RPC + 32'd4);
        end
    endtask

    task automatic test_reset_midfetch();
        do_fetch(0, 32'h5555_0001, 0);
        do_exec(1'b1, 5'd3, 32'h0BAD_F00D, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h5555_0002;
        #1;
        total++;
        if (imem.imem_req !== 1'b0 || pc !== RPC || instr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: got req=%b pc=%h instr=%h want 0 %h 0", imem.imem_req, pc, instr, RPC);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        rs1_addr = 5'd3;
        #1;
        total++;
        if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || rs1_data !== 32'h0) begin
            bad++;
            $display("FAIL ack_ignored_idle: got req=%b valid=%b r3=%h want 0 0 0",
                     imem.imem_req, instr_valid, rs1_data);
        end
        imem.imem_ack = 1'b0;
        do_fetch(0, 32'h5555_0003, 0);
        do_exec(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_regwrite();
        test_branch();
        test_back_to_back();
        test_exec_error();
        test_timeout();
        test_reset_midfetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
